// File: rtl/text_writer.sv
// Write-side front end for the 80x30 text tile buffer: turns a stream of character
// codes into single-tile writes, cursor moves, or a full-screen clear.
module text_writer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int CHAR_W = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CHAR_W-1:0] char_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              wr_en_o,
    output logic [6:0]        col_w_o,
    output logic [4:0]        row_w_o,
    output logic [CHAR_W-1:0] din_o,
    output logic [6:0]        cur_col_o,
    output logic [4:0]        cur_row_o
);

    localparam logic [6:0]        COL_LAST = 7'(COLS - 1);
    localparam logic [4:0]        ROW_LAST = 5'(ROWS - 1);
    localparam logic [CHAR_W-1:0] CH_SPACE = CHAR_W'(8'h20);
    localparam logic [CHAR_W-1:0] CH_TILDE = CHAR_W'(8'h7E);
    localparam logic [CHAR_W-1:0] CH_BS    = CHAR_W'(8'h08);
    localparam logic [CHAR_W-1:0] CH_LF    = CHAR_W'(8'h0A);
    localparam logic [CHAR_W-1:0] CH_FF    = CHAR_W'(8'h0C);
    localparam logic [CHAR_W-1:0] CH_CR    = CHAR_W'(8'h0D);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t            state_q, state_d;
    logic [6:0]        clr_col_q, clr_col_d;
    logic [4:0]        clr_row_q, clr_row_d;
    logic              clr_done_q, clr_done_d;
    logic              ready_d, wr_en_d;
    logic [6:0]        col_w_d, cur_col_d;
    logic [4:0]        row_w_d, cur_row_d;
    logic [CHAR_W-1:0] din_d;
    logic              accept;
    logic              is_print;

    function automatic logic [4:0] row_next(input logic [4:0] r);
        return (r == ROW_LAST) ? 5'd0 : r + 5'd1;
    endfunction

    // Row-major advance, returned as {row, col}; wraps the whole screen without scrolling.
    function automatic logic [11:0] advance(input logic [6:0] c, input logic [4:0] r);
        if (c == COL_LAST)
            return {row_next(r), 7'd0};
        else
            return {r, c + 7'd1};
    endfunction

    assign accept   = valid_i && ready_o;
    assign is_print = (char_i >= CH_SPACE) && (char_i <= CH_TILDE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_q <= S_CLEAR;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR: if (clr_done_q) state_d = S_IDLE;
            S_IDLE:  if (accept && char_i == CH_FF) state_d = S_CLEAR;
            default: state_d = S_CLEAR;
        endcase
    end

    always_comb begin
        wr_en_d    = 1'b0;
        col_w_d    = col_w_o;
        row_w_d    = row_w_o;
        din_d      = din_o;
        cur_col_d  = cur_col_o;
        cur_row_d  = cur_row_o;
        clr_col_d  = clr_col_q;
        clr_row_d  = clr_row_q;
        clr_done_d = clr_done_q;
        ready_d    = ready_o;
        case (state_q)
            S_CLEAR: begin
                if (!clr_done_q) begin
                    wr_en_d = 1'b1;
                    col_w_d = clr_col_q;
                    row_w_d = clr_row_q;
                    din_d   = CH_SPACE;
                    {clr_row_d, clr_col_d} = advance(clr_col_q, clr_row_q);
                    if (clr_col_q == COL_LAST && clr_row_q == ROW_LAST)
                        clr_done_d = 1'b1;
                    ready_d = 1'b0;
                end else begin
                    // One idle edge after the last tile write before accepting input.
                    ready_d    = 1'b1;
                    cur_col_d  = 7'd0;
                    cur_row_d  = 5'd0;
                    clr_col_d  = 7'd0;
                    clr_row_d  = 5'd0;
                    clr_done_d = 1'b0;
                end
            end
            S_IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    if (is_print) begin
                        wr_en_d = 1'b1;
                        col_w_d = cur_col_o;
                        row_w_d = cur_row_o;
                        din_d   = char_i;
                        {cur_row_d, cur_col_d} = advance(cur_col_o, cur_row_o);
                    end else begin
                        case (char_i)
                            CH_CR: cur_col_d = 7'd0;
                            CH_LF: begin
                                cur_col_d = 7'd0;
                                cur_row_d = row_next(cur_row_o);
                            end
                            CH_BS: begin
                                if (cur_col_o != 7'd0) begin
                                    cur_col_d = cur_col_o - 7'd1;
                                    wr_en_d   = 1'b1;
                                    col_w_d   = cur_col_o - 7'd1;
                                    row_w_d   = cur_row_o;
                                    din_d     = CH_SPACE;
                                end
                            end
                            CH_FF: begin
                                // The acceptance edge already drives tile (0,0).
                                wr_en_d    = 1'b1;
                                col_w_d    = 7'd0;
                                row_w_d    = 5'd0;
                                din_d      = CH_SPACE;
                                clr_col_d  = 7'd1;
                                clr_row_d  = 5'd0;
                                clr_done_d = 1'b0;
                                ready_d    = 1'b0;
                                cur_col_d  = 7'd0;
                                cur_row_d  = 5'd0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_en_o    <= 1'b0;
            col_w_o    <= 7'd0;
            row_w_o    <= 5'd0;
            din_o      <= '0;
            ready_o    <= 1'b0;
            cur_col_o  <= 7'd0;
            cur_row_o  <= 5'd0;
            clr_col_q  <= 7'd0;
            clr_row_q  <= 5'd0;
            clr_done_q <= 1'b0;
        end else begin
            wr_en_o    <= wr_en_d;
            col_w_o    <= col_w_d;
            row_w_o    <= row_w_d;
            din_o      <= din_d;
            ready_o    <= ready_d;
            cur_col_o  <= cur_col_d;
            cur_row_o  <= cur_row_d;
            clr_col_q  <= clr_col_d;
            clr_row_q  <= clr_row_d;
            clr_done_q <= clr_done_d;
        end
    end

endmodule

// File: tb/tb_text_writer.sv
// Scoreboard bench for text_writer: expected writes are queued as codes are sent
// and matched against every wr_en_o cycle.
module tb_text_writer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [6:0] char_i;
    logic       valid_i;
    logic       ready_o, wr_en_o;
    logic [6:0] col_w_o, din_o, cur_col_o;
    logic [4:0] row_w_o, cur_row_o;

    text_writer #(.COLS(80), .ROWS(30), .CHAR_W(7)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .char_i(char_i), .valid_i(valid_i),
        .ready_o(ready_o), .wr_en_o(wr_en_o), .col_w_o(col_w_o), .row_w_o(row_w_o),
        .din_o(din_o), .cur_col_o(cur_col_o), .cur_row_o(cur_row_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_chk = 0;
    int          n_err = 0;
    logic [18:0] wq[$];          // {col, row, din}
    logic [6:0]  ccol;
    logic [4:0]  crow;
    logic [6:0]  mem [0:2399];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk_i)
        if (wr_en_o) mem[int'(row_w_o) * 80 + int'(col_w_o)] <= din_o;

    always @(negedge clk_i) begin
        if (wr_en_o) begin
            if (wq.size() == 0)
                chk("wr_unexpected", {13'd0, col_w_o, row_w_o, din_o}, 32'h7FFFF);
            else
                chk("wr", {13'd0, col_w_o, row_w_o, din_o}, {13'd0, wq.pop_front()});
        end
    end

    task automatic push_clear();
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                wq.push_back({7'(c), 5'(r), 7'h20});
    endtask

    task automatic model(input logic [6:0] code);
        if (code >= 7'h20 && code <= 7'h7E) begin
            wq.push_back({ccol, crow, code});
            if (ccol == 7'd79) begin
                ccol = 7'd0;
                crow = (crow == 5'd29) ? 5'd0 : crow + 5'd1;
            end else begin
                ccol = ccol + 7'd1;
            end
        end else begin
            case (code)
                7'h0D: ccol = 7'd0;
                7'h0A: begin
                    ccol = 7'd0;
                    crow = (crow == 5'd29) ? 5'd0 : crow + 5'd1;
                end
                7'h08: if (ccol != 7'd0) begin
                    ccol = ccol - 7'd1;
                    wq.push_back({ccol, crow, 7'h20});
                end
                7'h0C: begin
                    push_clear();
                    ccol = 7'd0;
                    crow = 5'd0;
                end
                default: ;
            endcase
        end
    endtask

    // Leaves valid_i high so consecutive calls are back-to-back transfers.
    task automatic send(input logic [6:0] code);
        chk("ready_before_send", 32'(ready_o), 32'd1);
        char_i  = code;
        valid_i = 1'b1;
        model(code);
        @(posedge clk_i);
        #1;
        chk("cursor", {20'd0, cur_col_o, cur_row_o}, {20'd0, ccol, crow});
    endtask

    task automatic idle(input int cycles);
        valid_i = 1'b0;
        repeat (cycles) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(posedge clk_i);
            #1;
            n++;
        end while (!ready_o && n < 3000);
    endtask

    int n;

    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b0;
        char_i  = 7'h00;
        ccol    = 7'd0;
        crow    = 5'd0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_outputs", {ready_o, wr_en_o, col_w_o, row_w_o, din_o, cur_col_o, cur_row_o}, 32'd0);

        // Reset release: full clear, ready 2400 edges after the first active edge
        push_clear();
        rst_i = 1'b0;
        wait_ready(n);
        chk("rst_clear_len", 32'(n), 32'd2401);
        chk("rst_clear_q", 32'(wq.size()), 32'd0);
        chk("rst_cursor", {20'd0, cur_col_o, cur_row_o}, 32'd0);

        // Back-to-back print
        send(7'h41);
        send(7'h42);
        idle(2);
        chk("mem_1_0", 32'(mem[1]), 32'h42);

        // Column wrap then whole-screen wrap
        while (ccol != 7'd0) send(7'h61 + 7'(ccol % 26));
        chk("col_wrap_cursor", {20'd0, cur_col_o, cur_row_o}, {20'd0, 7'd0, 5'd1});
        send(7'h30);
        for (int i = 0; i < 2400 && !(ccol == 7'd79 && crow == 5'd29); i++)
            send(7'h21 + 7'(i % 90));
        send(7'h5A);
        chk("screen_wrap_cursor", {20'd0, cur_col_o, cur_row_o}, 32'd0);
        idle(2);
        chk("wrap_q", 32'(wq.size()), 32'd0);

        // Control codes from (5,3)
        repeat (3) send(7'h0A);
        repeat (5) send(7'h2E);
        send(7'h08);
        chk("bs_cursor", {20'd0, cur_col_o, cur_row_o}, {20'd0, 7'd4, 5'd3});
        send(7'h0D);
        send(7'h08);
        send(7'h0A);
        chk("lf_cursor", {20'd0, cur_col_o, cur_row_o}, {20'd0, 7'd0, 5'd4});
        while (crow != 5'd29) send(7'h0A);
        send(7'h0A);
        chk("lf_wrap_cursor", {20'd0, cur_col_o, cur_row_o}, 32'd0);
        send(7'h07);
        chk("bel_ready", 32'(ready_o), 32'd1);
        send(7'h7F);
        idle(2);
        chk("ctrl_q", 32'(wq.size()), 32'd0);

        // FF mid-screen with valid held through the clear
        repeat (10) send(7'h0A);
        repeat (10) send(7'h2A);
        chk("ff_start", {20'd0, cur_col_o, cur_row_o}, {20'd0, 7'd10, 5'd10});
        send(7'h0C);
        char_i = 7'h41;
        wait_ready(n);
        valid_i = 1'b0;
        chk("ff_clear_len", 32'(n), 32'd2400);
        idle(2);
        chk("ff_q", 32'(wq.size()), 32'd0);
        chk("ff_cursor", {20'd0, cur_col_o, cur_row_o}, 32'd0);

        // Reset during the 1000th clear write
        send(7'h0C);
        valid_i = 1'b0;
        repeat (999) @(posedge clk_i);
        #1;
        chk("pre_rst_wr", {wr_en_o, 6'd0, col_w_o, row_w_o}, {1'b1, 6'd0, 7'd39, 5'd12});
        rst_i = 1'b1;
        #1;
        chk("async_rst", {ready_o, wr_en_o, col_w_o, row_w_o, din_o, cur_col_o, cur_row_o}, 32'd0);
        wq.delete();
        repeat (2) @(posedge clk_i);
        #1;
        push_clear();
        ccol  = 7'd0;
        crow  = 5'd0;
        rst_i = 1'b0;
        wait_ready(n);
        chk("rerst_clear_len", 32'(n), 32'd2401);
        chk("rerst_q", 32'(wq.size()), 32'd0);
        send(7'h58);
        idle(2);
        chk("post_q", 32'(wq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/text_writer.md
# text_writer

Write-side front end for the 80x30 text tile buffer. Accepts a stream of 7-bit character codes over a valid/ready handshake, tracks a cursor, and converts each code into at most one write on the buffer's write port (`wr_en_i`, `col_w_i`, `row_w_i`, `din_i`), or into 2400 writes for a screen clear. Control codes move the cursor. The VGA read side of the buffer is unaffected and runs concurrently.

## Interface
- `COLS`, 80, tiles per row
- `ROWS`, 30, tile rows
- `CHAR_W`, 7, character code width
- `clk_i` in 1: pixel-domain clock shared with the buffer.
- `rst_i` in 1: asynchronous, active-high reset.
- `char_i` in 7: incoming character code.
- `valid_i` in 1: `char_i` is valid.
- `ready_o` out 1: writer can accept a code. Transfer happens on a rising edge where `valid_i && ready_o`.
- `wr_en_o` out 1: to buffer `wr_en_i`.
- `col_w_o` out 7: to buffer `col_w_i`.
- `row_w_o` out 5: to buffer `row_w_i`.
- `din_o` out 7: to buffer `din_i`.
- `cur_col_o` out 7: column where the next printable character will land.
- `cur_row_o` out 5: row where the next printable character will land.

## Operation
- States: CLEAR, IDLE. While `rst_i` is high, outputs are held at reset values.
- Reset values: `wr_en_o`=0, `col_w_o`=0, `row_w_o`=0, `din_o`=0, `ready_o`=0, `cur_col_o`=0, `cur_row_o`=0. State after reset is CLEAR.
- CLEAR:
  - Writes 0x20 to every tile in row-major order, (col 0, row 0) through (79, 29), one tile per cycle.
  - `ready_o`=0 throughout.
  - On completion: cursor=(0,0), state goes to IDLE.
- IDLE: `ready_o`=1. Accepted codes are handled as follows:
  - 0x20–0x7E, printable:
    - Write the code at the cursor.
    - Advance the cursor. If col is 79, go to col 0, row+1. If row is 29, wrap to row 0; there is no scrolling.
  - 0x0D, CR: col set to 0. No write.
  - 0x0A, LF: col set to 0, row+1 with wrap 29→0. No write.
  - 0x08, BS:
    - If col > 0: col-1, and write 0x20 at the new position.
    - If col is 0: no-op, no write.
  - 0x0C, FF: enter CLEAR.
  - All other codes, including 0x7F: consumed and ignored. No write, no cursor change.
- Arithmetic:
  - Column and row counters compare against `COLS-1` and `ROWS-1` explicitly.
  - Column values 80–127 and row values 30–31 are never driven.

## Timing
- All outputs are registered.
- A code accepted at edge N drives `wr_en_o`=1 with address and data valid during the cycle after edge N, for exactly one cycle. The buffer commits it at edge N+1.
- `cur_col_o`/`cur_row_o` update at edge N (same edge as the write outputs) to the post-command cursor.
- Back-to-back: with `valid_i` held high, one code is accepted per cycle and one write is issued per cycle. No bubbles.
- Clear timing:
  - The first edge with `rst_i` low (or the FF acceptance edge) drives write (0,0).
  - The 2400th write (79,29) is driven after edge E+2399.
  - Edge E+2400 drops `wr_en_o` and raises `ready_o`.
  - An FF accepted at edge N gives `ready_o`=0 from edge N through edge N+2399.
- When a non-writing code is accepted, `wr_en_o`=0 in the following cycle. `col_w_o`/`row_w_o`/`din_o` hold their previous values.
- Reset mid-clear or mid-stream:
  - All outputs go to reset values asynchronously.
  - The clear restarts from (0,0) after release. No partial state survives.

## Test plan
1. **Reset release.** Expect exactly 2400 consecutive cycles with `wr_en_o`=1 and `din_o`=0x20, addresses row-major from (0,0) to (79,29). `ready_o` rises 2400 edges after release, and cursor=(0,0).
2. **Back-to-back print.** Send 0x41 then 0x42 back-to-back. Expect writes (0,0)=0x41 and (1,0)=0x42 in consecutive cycles, and cursor=(2,0). A buffer read of (1,0) returns 0x42.
3. **Column and screen wrap.**
   - After 80 printable codes, cursor=(0,1). The 81st code writes (0,1).
   - Fill to cursor (79,29), then send 0x5A: expect a write at (79,29) and cursor=(0,0).
4. **Control codes.** Start with cursor at (5,3).
   - BS: expect a write of 0x20 at (4,3); cursor=(4,3).
   - CR: cursor=(0,3), no write.
   - BS: no write.
   - LF: cursor=(0,4), no write.
   - With cursor at row 29, LF: cursor=(0,0).
   - 0x07: no write, cursor unchanged, `ready_o` stays 1.
5. **FF mid-screen.** With cursor at (10,10), send 0x0C. Expect `ready_o`=0 for 2400 cycles, 2400 writes of 0x20, then cursor=(0,0). Holding `valid_i`=1 during the clear accepts nothing.
6. **Reset mid-clear.** Assert `rst_i` during the 1000th clear write. Expect `wr_en_o`=0 immediately (asynchronous). After release, the clear restarts at (0,0) and takes a full 2400 writes.
